// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
//
// Write-side companion of the CPU register file. ALU results and load results
// (the latter buffered in a small FIFO) are arbitrated onto the register
// file's single registered write port. A per-register scoreboard tracks
// pending writes so issue can stall on hazards, and a one-cycle-delayed copy
// of the write port is provided as a bypass record.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   ce              clock enable; when low all state holds
//   issue_valid/rd  issued instruction that will write issue_rd
//   alu_valid/rd/data   ALU result (always accepted while ce=1)
//   ld_valid/rd/data    load result offer; ld_ready = ce & !full
//   rf_rd_idx/rf_data_in/rf_write_en   registered register file write port
//   busy            scoreboard, bit i = write to register i pending
//   byp_valid/idx/data  write port as it was on the previous enabled edge
//   lq_count        load queue occupancy
// ---------------------------------------------------------------------------
module regfile_writeback #(
    parameter int REGISTER_WIDTH = 32,
    parameter int NREGS          = 32,
    parameter int LQ_DEPTH       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      issue_valid,
    input  logic [4:0]                issue_rd,
    input  logic                      alu_valid,
    input  logic [4:0]                alu_rd,
    input  logic [REGISTER_WIDTH-1:0] alu_data,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [4:0]                ld_rd,
    input  logic [REGISTER_WIDTH-1:0] ld_data,
    output logic [4:0]                rf_rd_idx,
    output logic [REGISTER_WIDTH-1:0] rf_data_in,
    output logic                      rf_write_en,
    output logic [NREGS-1:0]          busy,
    output logic                      byp_valid,
    output logic [4:0]                byp_idx,
    output logic [REGISTER_WIDTH-1:0] byp_data,
    output logic [$clog2(LQ_DEPTH):0] lq_count
);

    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Load queue storage and control
    logic [4:0]                lq_rd   [LQ_DEPTH];
    logic [REGISTER_WIDTH-1:0] lq_data [LQ_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;
    logic                      lq_full;
    logic                      lq_empty;
    logic                      push;
    logic                      pop;

    // Arbitration result
    logic                      sel_valid;
    logic [4:0]                sel_rd;
    logic [REGISTER_WIDTH-1:0] sel_data;
    logic [NREGS-1:0]          busy_next;

    assign lq_full  = (count == CNT_W'(LQ_DEPTH));
    assign lq_empty = (count == '0);
    assign ld_ready = ce & ~lq_full;
    assign push     = ld_valid & ld_ready;
    // The ALU has priority; the queue only drains in cycles without an ALU result.
    assign pop      = ce & ~alu_valid & ~lq_empty;
    assign lq_count = count;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sel_valid = alu_valid | ~lq_empty;
        sel_rd    = lq_rd[rd_ptr];
        sel_data  = lq_data[rd_ptr];
        if (alu_valid) begin
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end
    end

    // Scoreboard: the clear comes from the write being committed this edge;
    // the set is applied after it so a same-index issue wins.
    always_comb begin
        busy_next = busy;
        if (rf_write_en)
            busy_next[rf_rd_idx] = 1'b0;
        if (issue_valid && issue_rd != 5'd0)
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // NOTE: the queue storage is not reset; the pointers and count define
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            lq_rd[wr_ptr]   <= ld_rd;
            lq_data[wr_ptr] <= ld_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values (the bypass copy relies on this).
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_en <= 1'b0;
            rf_rd_idx   <= '0;
            rf_data_in  <= '0;
            byp_valid   <= 1'b0;
            byp_idx     <= '0;
            byp_data    <= '0;
            busy        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (ce) begin
            // A selected result for x0 is consumed but never written.
            rf_write_en <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid) begin
                rf_rd_idx  <= sel_rd;
                rf_data_in <= sel_data;
            end
            byp_valid <= rf_write_en;
            byp_idx   <= rf_rd_idx;
            byp_data  <= rf_data_in;
            busy      <= busy_next;
            // Depth is a power of two, so the pointers wrap naturally.
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback
//
// Self-checking bench for regfile_writeback: a table of single-cycle ALU /
// issue vectors with hand-computed expectations, followed by hand-written
// multi-cycle sequences (load queue fill/drain, x0 handling, scoreboard
// timing, clock-enable freeze and reset mid-operation).
// ---------------------------------------------------------------------------
module tb_regfile_writeback;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  rf_rd_idx;
    logic [31:0] rf_data_in;
    logic        rf_write_en;
    logic [31:0] busy;
    logic        byp_valid;
    logic [4:0]  byp_idx;
    logic [31:0] byp_data;
    logic [2:0]  lq_count;

    int checks   = 0;
    int failures = 0;

    regfile_writeback #(
        .REGISTER_WIDTH(32),
        .NREGS(32),
        .LQ_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .alu_valid(alu_valid),
        .alu_rd(alu_rd),
        .alu_data(alu_data),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_rd(ld_rd),
        .ld_data(ld_data),
        .rf_rd_idx(rf_rd_idx),
        .rf_data_in(rf_data_in),
        .rf_write_en(rf_write_en),
        .busy(busy),
        .byp_valid(byp_valid),
        .byp_idx(byp_idx),
        .byp_data(byp_data),
        .lq_count(lq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Occupancy can never exceed depth; an underflow would wrap past it too.
    always @(negedge clk) begin
        assert (lq_count <= 3'd4)
        else begin
            failures++;
            $display("FAIL lq_bound: lq_count=%0d exceeds 4", lq_count);
        end
    end

    typedef struct {
        logic        alu_valid;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        issue_valid;
        logic [4:0]  issue_rd;
        logic        exp_wen;
        logic [4:0]  exp_idx;
        logic [31:0] exp_data;
        logic        exp_bv;
        logic [4:0]  exp_bidx;
        logic [31:0] exp_bdata;
        logic [31:0] exp_busy;
    } vec_t;

    vec_t vec [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rf(input string name, input logic wen, input logic [4:0] idx,
                            input logic [31:0] data);
        check({name, ".wen"}, 32'(rf_write_en), 32'(wen));
        if (wen) begin
            check({name, ".idx"}, 32'(rf_rd_idx), 32'(idx));
            check({name, ".data"}, rf_data_in, data);
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1;
        issue_valid = 1'b0; issue_rd = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;

        //                alu            issue     rf expected            byp expected             busy
        vec[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        32'h0000_0020};
        vec[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'hDEADBEEF, 32'h0000_0000};
        vec[2] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd31, 1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 5'd0,  32'h0,        32'h8000_0000};
        vec[3] = '{1'b1, 5'd1,  32'h0,        1'b1, 5'd31, 1'b1, 5'd1,  32'h0,        1'b1, 5'd31, 32'hA5A5A5A5, 32'h8000_0000};
        vec[4] = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  32'h0,        32'h8000_0000};
        vec[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h8000_0000};
        vec[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        32'h8000_0000};
        vec[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'hFFFFFFFF, 32'h0000_0000};

        // Reset state
        step();
        step();
        check("rst.wen", 32'(rf_write_en), 32'd0);
        check("rst.idx", 32'(rf_rd_idx), 32'd0);
        check("rst.data", rf_data_in, 32'd0);
        check("rst.byp_valid", 32'(byp_valid), 32'd0);
        check("rst.byp_idx", 32'(byp_idx), 32'd0);
        check("rst.byp_data", byp_data, 32'd0);
        check("rst.busy", busy, 32'd0);
        check("rst.lq_count", 32'(lq_count), 32'd0);
        rst = 1'b0;

        // Table: ALU writes, x0 drop, bypass alignment, scoreboard set/clear
        for (int i = 0; i < 8; i++) begin
            alu_valid   = vec[i].alu_valid;
            alu_rd      = vec[i].alu_rd;
            alu_data    = vec[i].alu_data;
            issue_valid = vec[i].issue_valid;
            issue_rd    = vec[i].issue_rd;
            step();
            check_rf($sformatf("vec%0d", i), vec[i].exp_wen, vec[i].exp_idx, vec[i].exp_data);
            check($sformatf("vec%0d.byp_valid", i), 32'(byp_valid), 32'(vec[i].exp_bv));
            if (vec[i].exp_bv) begin
                check($sformatf("vec%0d.byp_idx", i), 32'(byp_idx), 32'(vec[i].exp_bidx));
                check($sformatf("vec%0d.byp_data", i), byp_data, vec[i].exp_bdata);
            end
            check($sformatf("vec%0d.busy", i), busy, vec[i].exp_busy);
            check($sformatf("vec%0d.lq_count", i), 32'(lq_count), 32'd0);
        end
        alu_valid = 1'b0; issue_valid = 1'b0;

        // Scoreboard timing for rd=7
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        check("sb.set", busy, 32'h80);
        for (int i = 0; i < 3; i++) begin
            step();
            check("sb.hold", busy, 32'h80);
        end
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        step();
        alu_valid = 1'b0;
        check_rf("sb.write", 1'b1, 5'd7, 32'h77);
        check("sb.before_clear", busy, 32'h80);
        step();
        check("sb.cleared", busy, 32'h0);
        alu_valid = 1'b1; alu_data = 32'h78;
        step();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        check("sb.set_wins", busy, 32'h80);
        step();
        check("sb.set_wins_hold", busy, 32'h80);
        alu_valid = 1'b1; alu_data = 32'h79;
        step();
        alu_valid = 1'b0;
        step();
        check("sb.final_clear", busy, 32'h0);

        // Load queue fill while the ALU holds the port, then in-order drain
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0;
        ld_valid  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            ld_rd   = 5'(k);
            ld_data = 32'(k * 32'h11);
            check($sformatf("fill%0d.ld_ready", k), 32'(ld_ready), 32'd1);
            step();
            check($sformatf("fill%0d.lq_count", k), 32'(lq_count), 32'(k));
            check_rf($sformatf("fill%0d", k), 1'b1, 5'd10, 32'hA0);
        end
        ld_rd = 5'd5; ld_data = 32'h55;
        check("full.ld_ready", 32'(ld_ready), 32'd0);
        step();
        check("full.lq_count", 32'(lq_count), 32'd4);
        check("full.ld_ready2", 32'(ld_ready), 32'd0);
        alu_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 2) ld_valid = 1'b0;
            check_rf($sformatf("drain%0d", k), 1'b1, 5'(k), 32'(k * 32'h11));
            check($sformatf("drain%0d.lq_count", k), 32'(lq_count),
                  (k == 1) ? 32'd3 : (k == 2) ? 32'd3 : 32'(5 - k));
        end
        step();
        check("drain.idle_wen", 32'(rf_write_en), 32'd0);

        // x0 results are consumed without a write
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        ld_valid  = 1'b1; ld_rd = 5'd0; ld_data = 32'h99;
        step();
        alu_valid = 1'b0; ld_valid = 1'b0;
        check("x0.alu_wen", 32'(rf_write_en), 32'd0);
        check("x0.queued", 32'(lq_count), 32'd1);
        step();
        check("x0.ld_wen", 32'(rf_write_en), 32'd0);
        check("x0.popped", 32'(lq_count), 32'd0);
        check("x0.busy", busy, 32'd0);

        // Three queued loads, then clock enable low
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h900 + 32'(k);
            ld_valid  = 1'b1; ld_rd = 5'(20 + k); ld_data = 32'h2000 + 32'(k);
            issue_valid = (k == 0); issue_rd = 5'd12;
            step();
        end
        check("ce.pre_count", 32'(lq_count), 32'd3);
        check("ce.pre_busy", busy, 32'h1000);
        ce = 1'b0;
        alu_rd = 5'd3; alu_data = 32'h333;
        ld_rd = 5'd23; ld_data = 32'h2003;
        issue_valid = 1'b1; issue_rd = 5'd13;
        #1;
        check("ce.ld_ready", 32'(ld_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("ce%0d.lq_count", k), 32'(lq_count), 32'd3);
            check_rf($sformatf("ce%0d", k), 1'b1, 5'd9, 32'h902);
            check($sformatf("ce%0d.byp_data", k), byp_data, 32'h901);
            check($sformatf("ce%0d.busy", k), busy, 32'h1000);
            check($sformatf("ce%0d.ld_ready", k), 32'(ld_ready), 32'd0);
        end

        // Reset while disabled discards everything
        rst = 1'b1;
        step();
        check("mrst.lq_count", 32'(lq_count), 32'd0);
        check("mrst.busy", busy, 32'd0);
        check("mrst.wen", 32'(rf_write_en), 32'd0);
        check("mrst.byp_valid", 32'(byp_valid), 32'd0);
        rst = 1'b0; ce = 1'b1;
        alu_valid = 1'b0; ld_valid = 1'b0; issue_valid = 1'b0;
        step();
        check("post.wen", 32'(rf_write_en), 32'd0);
        check("post.lq_count", 32'(lq_count), 32'd0);
        check("post.ld_ready", 32'(ld_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
